// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin scheduler that time-shares one WIDTH-bit adder datapath
// among NUM_REQ requesters. One operation is in flight at a time:
// IDLE grants the first valid requester at or above the rotating pointer,
// EXEC holds the operands on x/y/cin for ADDER_LAT cycles, and RESP
// presents the captured sum/cout tagged with the requester index until
// the consumer accepts it.
//
// Ports:
//   clk, reset       clock (posedge) and synchronous active-low reset
//   req_valid/ready  per-requester handshake; req_ready is at most one-hot
//   req_x/y/cin      packed operands, requester i at [i*WIDTH +: WIDTH]
//   x, y, cin        registered operands driven to the shared adder
//   sum, cout        adder result, sampled ADDER_LAT edges after launch
//   rsp_valid/ready  response handshake
//   rsp_id/sum/cout  served requester index and captured result
//   busy             high whenever the scheduler is not idle
module adder_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int ADDER_LAT = 1,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int CW       = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         x,
  output logic [WIDTH-1:0]         y,
  output logic                     cin,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [WIDTH-1:0] opx [NUM_REQ];
  logic [WIDTH-1:0] opy [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign opx[i] = req_x[i*WIDTH +: WIDTH];
    assign opy[i] = req_y[i*WIDTH +: WIDTH];
  end

  logic           grant_any;
  logic [IDW-1:0] grant_idx;

  // Rotating priority search: first valid requester at or above ptr_q,
  // wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    cin_d     = cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    rsp_id_d  = rsp_id_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          x_d     = opx[grant_idx];
          y_d     = opy[grant_idx];
          cin_d   = req_cin[grant_idx];
          gid_d   = grant_idx;
          cnt_d   = CW'(ADDER_LAT - 1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          sum_d    = sum;
          cout_d   = cout;
          rsp_id_d = gid_q;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          // Pointer moves past the served requester only once its response
          // is consumed, so a stalled consumer cannot skew fairness.
          ptr_d   = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign cin       = cin_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));

  a_rsp_stable: assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_id) && $stable(rsp_sum) && $stable(rsp_cout)));

  a_operands_held: assert property (@(posedge clk) disable iff (!reset)
    (state_q == S_EXEC) |=> ($stable(x) && $stable(y) && $stable(cin)));

endmodule

// File: tb/tb_adder_rr_scheduler.sv
module tb_adder_rr_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           use3;
  logic [N-1:0]   rv_drv;
  logic [N*W-1:0] req_x, req_y;
  logic [N-1:0]   req_cin;
  logic           rsp_ready;

  // Instance A: ADDER_LAT=1 with an ideal combinational adder
  logic [N-1:0] rv1, rr1;
  logic [W-1:0] x1, y1, sum1, rsum1;
  logic         cin1, cout1, rvalid1, rready1, rcout1, busy1;
  logic [1:0]   rid1;
  // Instance B: ADDER_LAT=3 with a 3-cycle adder
  logic [N-1:0] rv3, rr3;
  logic [W-1:0] x3, y3, sum3, rsum3;
  logic         cin3, cout3, rvalid3, rready3, rcout3, busy3;
  logic [1:0]   rid3;

  assign rv1     = use3 ? '0 : rv_drv;
  assign rv3     = use3 ? rv_drv : '0;
  assign rready1 = use3 ? 1'b0 : rsp_ready;
  assign rready3 = use3 ? rsp_ready : 1'b0;

  adder_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .ADDER_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rr1),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .x(x1), .y(y1), .cin(cin1), .sum(sum1), .cout(cout1),
    .rsp_valid(rvalid1), .rsp_ready(rready1), .rsp_id(rid1),
    .rsp_sum(rsum1), .rsp_cout(rcout1), .busy(busy1));

  adder_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .ADDER_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .x(x3), .y(y3), .cin(cin3), .sum(sum3), .cout(cout3),
    .rsp_valid(rvalid3), .rsp_ready(rready3), .rsp_id(rid3),
    .rsp_sum(rsum3), .rsp_cout(rcout3), .busy(busy3));

  assign {cout1, sum1} = {1'b0, x1} + {1'b0, y1} + 9'(cin1);

  logic [W:0] p1, p2;
  always @(posedge clk) begin
    p1 <= {1'b0, x3} + {1'b0, y3} + 9'(cin3);
    p2 <= p1;
  end
  assign {cout3, sum3} = p2;

  // Muxed view of whichever instance is under test
  logic [N-1:0] rr;
  logic [W-1:0] xo, yo, rsum;
  logic         cino, rv, rcout, bsy;
  logic [1:0]   rid;
  assign rr    = use3 ? rr3 : rr1;
  assign xo    = use3 ? x3 : x1;
  assign yo    = use3 ? y3 : y1;
  assign cino  = use3 ? cin3 : cin1;
  assign rv    = use3 ? rvalid3 : rvalid1;
  assign rid   = use3 ? rid3 : rid1;
  assign rsum  = use3 ? rsum3 : rsum1;
  assign rcout = use3 ? rcout3 : rcout1;
  assign bsy   = use3 ? busy3 : busy1;

  int total = 0;
  int bad   = 0;
  int ptr_m [2];

  function automatic int pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
  endtask

  // One complete transaction against the model: grant, operand launch,
  // latency, result, optional backpressure, response handshake.
  task automatic run_op(input logic [N-1:0] mask, input int bp);
    int s, g, lat, cyc;
    logic [W-1:0] ex, ey;
    logic ec;
    logic [W:0] full;
    s   = use3 ? 1 : 0;
    lat = use3 ? 3 : 1;
    g   = pick(mask, ptr_m[s]);
    ex  = req_x[g*W +: W];
    ey  = req_y[g*W +: W];
    ec  = req_cin[g];
    full = {1'b0, ex} + {1'b0, ey} + 9'(ec);
    rv_drv = mask;
    #1;
    total++;
    if (rr !== N'(1 << g)) begin
      bad++; $display("FAIL grant: req_ready=%b expected=%b", rr, N'(1 << g));
    end
    @(posedge clk); #1;
    rv_drv = '0;
    total++;
    if ({xo, yo, cino, bsy, rv} !== {ex, ey, ec, 1'b1, 1'b0}) begin
      bad++; $display("FAIL launch: x=%h y=%h cin=%b busy=%b rsp_valid=%b expected x=%h y=%h cin=%b busy=1 rsp_valid=0",
                      xo, yo, cino, bsy, rv, ex, ey, ec);
    end
    cyc = 0;
    while (rv !== 1'b1 && cyc < lat + 4) begin
      @(posedge clk); #1;
      cyc++;
      total++;
      if ({xo, yo, cino} !== {ex, ey, ec}) begin
        bad++; $display("FAIL hold: x=%h y=%h cin=%b expected %h %h %b", xo, yo, cino, ex, ey, ec);
      end
    end
    total++;
    if (cyc != lat) begin
      bad++; $display("FAIL latency: edges=%0d expected=%0d", cyc, lat);
    end
    total++;
    if ({rid, rsum, rcout} !== {2'(g), full[W-1:0], full[W]}) begin
      bad++; $display("FAIL result: id=%0d sum=%h cout=%b expected id=%0d sum=%h cout=%b",
                      rid, rsum, rcout, g, full[W-1:0], full[W]);
    end
    for (int i = 0; i < bp; i++) begin
      rv_drv = '1;
      @(posedge clk); #1;
      total++;
      if ({rv, bsy, rr, rid, rsum, rcout} !== {1'b1, 1'b1, N'(0), 2'(g), full[W-1:0], full[W]}) begin
        bad++; $display("FAIL backpressure: valid=%b busy=%b ready=%b id=%0d sum=%h cout=%b expected 1 1 0000 %0d %h %b",
                        rv, bsy, rr, rid, rsum, rcout, g, full[W-1:0], full[W]);
      end
    end
    rv_drv = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if ({rv, bsy} !== 2'b00) begin
      bad++; $display("FAIL release: rsp_valid=%b busy=%b expected 0 0", rv, bsy);
    end
    ptr_m[s] = (g + 1) % N;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({x1, y1, cin1, rvalid1, rid1, rsum1, rcout1, busy1, rr1} !== '0) begin
      bad++; $display("FAIL reset_a: x=%h y=%h cin=%b valid=%b id=%0d sum=%h cout=%b busy=%b ready=%b expected all 0",
                      x1, y1, cin1, rvalid1, rid1, rsum1, rcout1, busy1, rr1);
    end
    total++;
    if ({x3, y3, cin3, rvalid3, rid3, rsum3, rcout3, busy3, rr3} !== '0) begin
      bad++; $display("FAIL reset_b: x=%h y=%h cin=%b valid=%b id=%0d sum=%h cout=%b busy=%b ready=%b expected all 0",
                      x3, y3, cin3, rvalid3, rid3, rsum3, rcout3, busy3, rr3);
    end
    rv_drv = '1;
    #1;
    total++;
    if (rr !== 4'b0001) begin
      bad++; $display("FAIL reset_ptr: req_ready=%b expected=0001", rr);
    end
    rv_drv = '0;
  endtask

  task automatic test_single();
    req_x[0*W +: W] = 8'h0F; req_y[0*W +: W] = 8'h01; req_cin[0] = 1'b0;
    run_op(4'b0001, 0);
  endtask

  task automatic test_overflow();
    req_x[2*W +: W] = 8'hFF; req_y[2*W +: W] = 8'h01; req_cin[2] = 1'b1;
    run_op(4'b0100, 0);
  endtask

  task automatic test_back_to_back();
    int ids [6];
    int tms [6];
    int n, cyc;
    do_reset();
    rv_drv = '1;
    rsp_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      total++;
      if (!$onehot0(rr)) begin
        bad++; $display("FAIL b2b_onehot: req_ready=%b", rr);
      end
      if (rv === 1'b1) begin
        ids[n] = int'(rid);
        tms[n] = cyc;
        n++;
        if (n == 6) rv_drv = '0;
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (n != 6) begin
      bad++; $display("FAIL b2b_count: responses=%0d expected=6", n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (ids[i] != i % N || tms[i] != 2 + 3 * i) begin
        bad++; $display("FAIL b2b_order: resp %0d id=%0d cycle=%0d expected id=%0d cycle=%0d",
                        i, ids[i], tms[i], i % N, 2 + 3 * i);
      end
    end
    ptr_m[0] = 2;
  endtask

  task automatic test_backpressure();
    req_x = $urandom; req_y = $urandom; req_cin = 4'($urandom);
    run_op('1, 5);
    run_op('1, 0);
  endtask

  task automatic test_reset_midop();
    req_x[3*W +: W] = 8'h5A; req_y[3*W +: W] = 8'h33; req_cin[3] = 1'b1;
    rv_drv = 4'b1000;
    #1;
    total++;
    if (rr !== 4'b1000) begin
      bad++; $display("FAIL midop_grant: req_ready=%b expected=1000", rr);
    end
    @(posedge clk); #1;
    rv_drv = '0;
    total++;
    if ({bsy, xo} !== {1'b1, 8'h5A}) begin
      bad++; $display("FAIL midop_exec: busy=%b x=%h expected 1 5a", bsy, xo);
    end
    do_reset();
    total++;
    if ({xo, yo, cino, rv, rid, rsum, rcout, bsy} !== '0) begin
      bad++; $display("FAIL midop_reset: x=%h y=%h cin=%b valid=%b id=%0d sum=%h cout=%b busy=%b expected all 0",
                      xo, yo, cino, rv, rid, rsum, rcout, bsy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rv !== 1'b0) begin
        bad++; $display("FAIL midop_norsp: rsp_valid=%b expected=0", rv);
      end
    end
    req_x = $urandom; req_y = $urandom; req_cin = 4'($urandom);
    run_op(4'b1010, 0);
  endtask

  task automatic test_lat3();
    use3 = 1'b1;
    req_x[1*W +: W] = 8'h01; req_y[1*W +: W] = 8'h01; req_cin[1] = 1'b0;
    run_op(4'b0010, 0);
    req_x[2*W +: W] = 8'h80; req_y[2*W +: W] = 8'h80; req_cin[2] = 1'b0;
    run_op(4'b0100, 2);
    use3 = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      use3 = it[0];
      req_x = $urandom; req_y = $urandom; req_cin = 4'($urandom);
      run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
    end
    use3 = 1'b0;
  endtask

  initial begin
    reset = 1'b0; use3 = 1'b0; rv_drv = '0; rsp_ready = 1'b0;
    req_x = '0; req_y = '0; req_cin = '0;
    ptr_m[0] = 0; ptr_m[1] = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_lat3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Round-robin scheduler that shares one 8-bit adder datapath (x, y, cin -> sum, cout) among NUM_REQ requesters. It accepts one operation at a time through a valid/ready handshake. It drives and holds the adder operands for ADDER_LAT cycles, captures sum/cout, and returns a tagged response through a valid/ready handshake. It sits between requester-side logic and the shared adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/sum width; matches adder datapath
ADDER_LAT, 1, cycles from operand launch to sum/cout valid (>=1)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, at most one-hot
req_x  input  NUM_REQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH]
req_y  input  NUM_REQ*WIDTH  operand y, same packing
req_cin  input  NUM_REQ  carry-in per requester
x  output  WIDTH  to adder, registered
y  output  WIDTH  to adder, registered
cin  output  1  to adder, registered
sum  input  WIDTH  from adder
cout  input  1  from adder
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  $clog2(NUM_REQ)  index of requester served
rsp_sum  output  WIDTH  captured sum
rsp_cout  output  1  captured carry-out
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; rr pointer=0; x, y, cin, rsp_sum, rsp_cout, rsp_id, rsp_valid, busy all 0; latency counter=0. Reset takes priority over all other events and aborts any in-flight op with no response. The requester must re-present its request.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req_ready is combinational and one-hot: it selects the first asserted req_valid searching from the pointer upward, modulo NUM_REQ.
  - All req_ready bits are 0 if no req_valid is asserted; state and pointer are then unchanged.
  - On handshake (req_valid[g] & req_ready[g]) at a posedge: register x/y/cin from requester g, store g, counter=ADDER_LAT-1, go to EXEC.
- EXEC:
  - x/y/cin are held stable and req_ready=0.
  - When counter==0 at a posedge: capture sum->rsp_sum, cout->rsp_cout, g->rsp_id, set rsp_valid=1, go to RESP.
  - Otherwise the counter decrements.
  - sum/cout are sampled exactly ADDER_LAT posedges after the acceptance edge.
- RESP:
  - rsp_valid=1; rsp_* are held stable until the handshake; req_ready=0 (backpressure blocks new grants).
  - On rsp_valid & rsp_ready at a posedge: rsp_valid=0, pointer=(g+1) mod NUM_REQ, go to IDLE.
  - x/y/cin keep their last values.
- Pointer advances only on a completed response, which gives fairness: a continuously requesting requester waits at most NUM_REQ-1 ops.
- Throughput is one op per ADDER_LAT+2 cycles when rsp_ready is held 1.
- Arithmetic: no modification of the adder result. sum wraps modulo 2^WIDTH; carry appears only on cout.
- Requesters must hold req_valid and operands stable until accepted. A valid dropped before acceptance simply loses arbitration.
- Simultaneous rsp handshake and new req_valid: the grant is not issued in the same cycle; it happens in the IDLE cycle that follows.
- Assertions:
  - $onehot0(req_ready);
  - rsp_* stable while rsp_valid & !rsp_ready;
  - x/y/cin stable throughout EXEC.

Test Plan:
1. Single op, ADDER_LAT=1, req 0 with x=8'h0F, y=8'h01, cin=0, ideal adder model -> req_ready[0] high in IDLE; rsp_valid rises 1 posedge after acceptance with rsp_id=0, rsp_sum=8'h10, rsp_cout=0.
2. Overflow: req 2 with x=8'hFF, y=8'h01, cin=1 -> rsp_id=2, rsp_sum=8'h01, rsp_cout=1.
3. All 4 req_valid held high from reset release, rsp_ready=1 -> service order 0,1,2,3,0,1; one op every 3 cycles; req_ready never multi-hot.
4. Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_sum/rsp_id stable, req_ready=0 throughout, busy=1; on release the next grant goes to g+1.
5. Reset pulse (reset=0 one cycle) during EXEC of req 3 -> next posedge all outputs 0, no response emitted; after re-request with req 1 and req 3 both valid, req 1 is served first (pointer=0).
6. ADDER_LAT=3 build, adder model with 3-cycle delay, x=8'h80, y=8'h80, cin=0 -> x/y held 3 cycles; rsp_sum=8'h00, rsp_cout=1; sampling a cycle early would return stale data and is flagged by the scoreboard.
